// File: rtl/pipelined_wallace_multiplier.sv
// Wallace-tree multiplier with registered 3:2 CSA layers and a final carry-propagate adder.
// Optional feature macro: WALLACE_SIGNED_EN (adds signed_mode, Baugh-Wooley two's complement).
module pipelined_wallace_multiplier #(
    parameter int WIDTH       = 32,
    parameter int PIPE_STAGES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
`ifdef WALLACE_SIGNED_EN
    input  logic                 signed_mode,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic [2:0]           in_flight
);

    typedef logic [2*WIDTH-1:0] row_t;

`ifdef WALLACE_SIGNED_EN
    localparam int R = WIDTH + 1;
`else
    localparam int R = WIDTH;
`endif

    function automatic int rows_after(int n, int k);
        int m;
        m = n;
        for (int i = 0; i < k; i++) m = (m / 3) * 2 + m % 3;
        return m;
    endfunction

    function automatic int num_layers(int n);
        int m;
        int l;
        m = n;
        l = 0;
        while (m > 2) begin
            m = (m / 3) * 2 + m % 3;
            l++;
        end
        return l;
    endfunction

    localparam int NL = num_layers(R);

    row_t                 w_pp       [R];
    row_t                 w_stage_in [PIPE_STAGES][R];
    row_t                 w_sum;
    logic [PIPE_STAGES:0] w_vchain;
    logic                 w_adv;
    logic                 w_in_xfer;
    logic                 w_out_xfer;

    logic [PIPE_STAGES-1:0] r_vld;
    row_t                   r_prod;
    logic [2:0]             r_cnt;

    // Partial products; in signed mode the Baugh-Wooley terms are inverted
    // and the constant 2^W + 2^(2W-1) rides in the extra row.
    always_comb begin
        logic [WIDTH-1:0] w_row;
        w_row = '0;
        for (int j = 0; j < R; j++) w_pp[j] = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_row = a & {WIDTH{b[i]}};
`ifdef WALLACE_SIGNED_EN
            if (signed_mode) begin
                if (i == WIDTH - 1) w_row[WIDTH-2:0] = ~w_row[WIDTH-2:0];
                else                w_row[WIDTH-1]   = ~w_row[WIDTH-1];
            end
`endif
            w_pp[i] = row_t'(w_row) << i;
        end
`ifdef WALLACE_SIGNED_EN
        if (signed_mode)
            w_pp[WIDTH] = (row_t'(1) << WIDTH) | (row_t'(1) << (2 * WIDTH - 1));
`endif
    end

    for (genvar j = 0; j < R; j++) begin : g_in
        assign w_stage_in[0][j] = w_pp[j];
    end

    assign w_vchain   = {r_vld, in_valid};
    assign out_valid  = w_vchain[PIPE_STAGES];
    assign w_adv      = ~(out_valid & ~out_ready);
    assign in_ready   = w_adv;
    assign w_in_xfer  = in_valid & w_adv;
    assign w_out_xfer = out_valid & out_ready;

    for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
        localparam int LO = (NL * s) / PIPE_STAGES;
        localparam int HI = (NL * (s + 1)) / PIPE_STAGES;

        row_t w_lay [HI-LO+1][R];

        for (genvar j = 0; j < R; j++) begin : g_src
            assign w_lay[0][j] = w_stage_in[s][j];
        end

        for (genvar k = LO; k < HI; k++) begin : g_layer
            localparam int N = rows_after(R, k);
            localparam int G = N / 3;
            for (genvar j = 0; j < R; j++) begin : g_row
                if (j < 2 * G) begin : g_csa
                    localparam int X = 3 * (j / 2);
                    row_t w_x;
                    row_t w_y;
                    row_t w_z;
                    assign w_x = w_lay[k-LO][X];
                    assign w_y = w_lay[k-LO][X+1];
                    assign w_z = w_lay[k-LO][X+2];
                    if (j % 2 == 0) begin : g_s
                        assign w_lay[k-LO+1][j] = w_x ^ w_y ^ w_z;
                    end else begin : g_c
                        assign w_lay[k-LO+1][j] =
                            ((w_x & w_y) | (w_x & w_z) | (w_y & w_z)) << 1;
                    end
                end else if (j < 2 * G + N % 3) begin : g_pass
                    assign w_lay[k-LO+1][j] = w_lay[k-LO][j + G];
                end else begin : g_zero
                    assign w_lay[k-LO+1][j] = '0;
                end
            end
        end

        if (s < PIPE_STAGES - 1) begin : g_reg
            row_t r_st [R];
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    r_st <= '{default: '0};
                else if (w_adv && w_vchain[s])
                    r_st <= w_lay[HI-LO];
            end
            for (genvar j = 0; j < R; j++) begin : g_out
                assign w_stage_in[s+1][j] = r_st[j];
            end
        end else begin : g_final
            assign w_sum = w_lay[HI-LO][0] + w_lay[HI-LO][1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld  <= '0;
            r_prod <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_adv) r_vld <= w_vchain[PIPE_STAGES-1:0];
            // Bubbles leave the last product untouched
            if (w_adv && w_vchain[PIPE_STAGES-1]) r_prod <= w_sum;
            unique case ({w_in_xfer, w_out_xfer})
                2'b10:   r_cnt <= r_cnt + 3'd1;
                2'b01:   r_cnt <= r_cnt - 3'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign product   = r_prod;
    assign in_flight = r_cnt;

endmodule

// File: tb/tb_pipelined_wallace_multiplier.sv
// Directed testbench for pipelined_wallace_multiplier (WIDTH=32, PIPE_STAGES=3).
module tb_pipelined_wallace_multiplier;

    localparam int W = 32;
    localparam int P = 3;

    typedef logic [2*W-1:0] prod_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    prod_t        product;
    logic [2:0]   in_flight;
`ifdef WALLACE_SIGNED_EN
    logic         signed_mode;
`endif

    int errors;
    int checks;

    pipelined_wallace_multiplier #(.WIDTH(W), .PIPE_STAGES(P)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef WALLACE_SIGNED_EN
        .signed_mode(signed_mode),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .in_flight (in_flight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          output prod_t p, output int lat);
        @(negedge clk);
        in_valid  = 1'b1;
        a         = x;
        b         = y;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        p = product;
    endtask

    task automatic test_reset();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        rst       = 1'b0;
        #1 rst    = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0)
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        if (out_valid !== 1'b0) errors++;
        checks++;
        if (product !== '0) begin
            $display("FAIL reset_product: got %h expected 0", product);
            errors++;
        end
        checks++;
        if (in_flight !== 3'd0) begin
            $display("FAIL reset_in_flight: got %0d expected 0", in_flight);
            errors++;
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
            errors++;
        end
    endtask

    task automatic test_basic();
        prod_t p;
        int    lat;
        run_op(32'd3, 32'd5, p, lat);
        checks++;
        if (lat !== P) begin
            $display("FAIL basic_latency: got %0d expected %0d", lat, P);
            errors++;
        end
        checks++;
        if (p !== prod_t'(15)) begin
            $display("FAIL basic_product: got %h expected %h", p, prod_t'(15));
            errors++;
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_flight !== 3'd0) begin
            $display("FAIL basic_drain: got valid=%b cnt=%0d expected 0/0",
                     out_valid, in_flight);
            errors++;
        end
    endtask

    task automatic test_vectors();
        logic [W-1:0] va [6];
        logic [W-1:0] vb [6];
        prod_t        ve [6];
        prod_t        p;
        int           lat;
        va[0] = 32'hFFFF_FFFF; vb[0] = 32'hFFFF_FFFF; ve[0] = 64'hFFFF_FFFE_0000_0001;
        va[1] = 32'h8000_0000; vb[1] = 32'h8000_0000; ve[1] = 64'h4000_0000_0000_0000;
        va[2] = 32'hFFFF_FFFF; vb[2] = 32'h0000_0001; ve[2] = 64'h0000_0000_FFFF_FFFF;
        va[3] = 32'h0000_0000; vb[3] = 32'hFFFF_FFFF; ve[3] = 64'h0;
        va[4] = 32'h0001_0000; vb[4] = 32'h0001_0000; ve[4] = 64'h0000_0001_0000_0000;
        va[5] = 32'h0000_FFFF; vb[5] = 32'h0000_FFFF; ve[5] = 64'h0000_0000_FFFE_0001;
        for (int i = 0; i < 6; i++) begin
            run_op(va[i], vb[i], p, lat);
            checks++;
            if (lat !== P || p !== ve[i]) begin
                $display("FAIL vector_%0d: got %h lat %0d expected %h lat %0d",
                         i, p, lat, ve[i], P);
                errors++;
            end
        end
        @(negedge clk);
    endtask

`ifdef WALLACE_SIGNED_EN
    task automatic test_signed();
        logic [W-1:0] va [4];
        logic [W-1:0] vb [4];
        prod_t        ve [4];
        prod_t        p;
        int           lat;
        va[0] = 32'hFFFF_FFFF; vb[0] = 32'hFFFF_FFFF; ve[0] = 64'h1;
        va[1] = 32'h8000_0000; vb[1] = 32'h0000_0002; ve[1] = 64'hFFFF_FFFF_0000_0000;
        va[2] = 32'h8000_0000; vb[2] = 32'h8000_0000; ve[2] = 64'h4000_0000_0000_0000;
        va[3] = 32'h0000_0003; vb[3] = 32'hFFFF_FFFB; ve[3] = 64'hFFFF_FFFF_FFFF_FFF1;
        signed_mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], p, lat);
            checks++;
            if (lat !== P || p !== ve[i]) begin
                $display("FAIL signed_%0d: got %h lat %0d expected %h lat %0d",
                         i, p, lat, ve[i], P);
                errors++;
            end
        end
        signed_mode = 1'b0;
        @(negedge clk);
    endtask
`endif

    task automatic test_back_to_back();
        int k;
        k = 1;
        out_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== (c >= 3 && c <= 10)) begin
                $display("FAIL b2b_valid c%0d: got %b expected %b",
                         c, out_valid, (c >= 3 && c <= 10));
                errors++;
            end
            if (out_valid === 1'b1) begin
                checks++;
                if (product !== prod_t'(k * k)) begin
                    $display("FAIL b2b_product c%0d: got %h expected %h",
                             c, product, prod_t'(k * k));
                    errors++;
                end
                k++;
            end
            if (c >= 3 && c <= 8) begin
                checks++;
                if (in_flight !== 3'd3) begin
                    $display("FAIL b2b_in_flight c%0d: got %0d expected 3", c, in_flight);
                    errors++;
                end
            end
            if (c < 8) begin
                in_valid = 1'b1;
                a        = W'(c + 1);
                b        = W'(c + 1);
            end else begin
                in_valid = 1'b0;
            end
        end
        checks++;
        if (k !== 9) begin
            $display("FAIL b2b_count: got %0d expected 8", k - 1);
            errors++;
        end
    endtask

    task automatic test_stall();
        prod_t exp_q [$];
        prod_t held;
        int    sent;
        int    got;
        sent = 0;
        got  = 0;
        held = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            out_ready = !(c >= 4 && c <= 8);
            if (sent < 6) begin
                in_valid = 1'b1;
                a        = W'(sent + 10);
                b        = W'(sent + 3);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c >= 4 && c <= 8) begin
                checks++;
                if (out_valid !== 1'b1 || in_ready !== 1'b0 || in_flight !== 3'd3) begin
                    $display("FAIL stall_state c%0d: got v=%b rdy=%b cnt=%0d expected 1/0/3",
                             c, out_valid, in_ready, in_flight);
                    errors++;
                end
                if (c == 4) begin
                    held = product;
                end else begin
                    checks++;
                    if (product !== held) begin
                        $display("FAIL stall_hold c%0d: got %h expected %h", c, product, held);
                        errors++;
                    end
                end
            end
            checks++;
            if (in_flight > 3'd3) begin
                $display("FAIL stall_in_flight c%0d: got %0d expected <=3", c, in_flight);
                errors++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(prod_t'((sent + 10) * (sent + 3)));
                sent++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL stall_extra c%0d: got %h expected none", c, product);
                    errors++;
                end else begin
                    if (product !== exp_q[0]) begin
                        $display("FAIL stall_product c%0d: got %h expected %h",
                                 c, product, exp_q[0]);
                        errors++;
                    end
                    void'(exp_q.pop_front());
                end
                got++;
            end
            if (sent == 6 && got == 6) break;
        end
        checks++;
        if (sent !== 6 || got !== 6) begin
            $display("FAIL stall_count: got sent=%0d recv=%0d expected 6/6", sent, got);
            errors++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                $display("FAIL stall_dup: got out_valid=%b expected 0", out_valid);
                errors++;
            end
        end
    endtask

    task automatic test_reset_mid();
        prod_t p;
        int    lat;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        a        = 32'd100;
        b        = 32'd100;
        @(negedge clk);
        a        = 32'd200;
        b        = 32'd200;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (in_flight !== 3'd2) begin
            $display("FAIL rstmid_pre: got %0d expected 2", in_flight);
            errors++;
        end
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_flight !== 3'd0) begin
            $display("FAIL rstmid_clear: got v=%b cnt=%0d expected 0/0", out_valid, in_flight);
            errors++;
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            $display("FAIL rstmid_ready: got %b expected 1", in_ready);
            errors++;
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                $display("FAIL rstmid_ghost c%0d: got %h expected no result", c, product);
                errors++;
            end
        end
        run_op(32'd7, 32'd6, p, lat);
        checks++;
        if (lat !== P || p !== prod_t'(42)) begin
            $display("FAIL rstmid_after: got %h lat %0d expected %h lat %0d",
                     p, lat, prod_t'(42), P);
            errors++;
        end
        @(negedge clk);
    endtask

    initial begin
        errors = 0;
        checks = 0;
`ifdef WALLACE_SIGNED_EN
        signed_mode = 1'b0;
`endif
        test_reset();
        test_basic();
        test_vectors();
`ifdef WALLACE_SIGNED_EN
        test_signed();
`endif
        test_back_to_back();
        test_stall();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipelined_wallace_multiplier.md
PIPELINED_WALLACE_MULTIPLIER -- requirements
Module: pipelined_wallace_multiplier

Interface
REQ-001 Parameter WIDTH, default 32, operand width; legal range 4..64.
REQ-002 Parameter PIPE_STAGES, default 3, number of register stages in the CSA tree and final adder; legal range 1..4.
REQ-003 Port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  reset; asynchronous and active-high.
REQ-005 Port in_valid  input  1  operands a and b are presented.
REQ-006 Port in_ready  output  1  block accepts an operand pair this cycle.
REQ-007 Port a  input  WIDTH  multiplicand.
REQ-008 Port b  input  WIDTH  multiplier.
REQ-009 Port out_valid  output  1  product is valid.
REQ-010 Port out_ready  input  1  downstream accepts the product.
REQ-011 Port product  output  2*WIDTH  result.
REQ-012 Port in_flight  output  3  count of valid entries held in the pipeline, range 0..PIPE_STAGES.
REQ-013 Port signed_mode  input  1  present only when WALLACE_SIGNED_EN is defined; 1 treats a, b and product as two's complement.

Function
REQ-014 Partial products SHALL be the AND of a with each bit of b, shifted by the bit index and reduced by 3:2 carry-save layers to two rows, then summed by one carry-propagate adder.
REQ-015 The reduction layers SHALL be split as evenly as possible across PIPE_STAGES; the last stage holds the final adder output.
REQ-016 An input transfer SHALL occur when in_valid and in_ready are both 1; an output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-017 The pipeline SHALL have stall = out_valid and not out_ready; in_ready = not stall, combinationally.
REQ-018 When not stalled, all stages SHALL advance together every cycle. Empty stages advance as bubbles; bubbles are not collapsed.
REQ-019 Latency SHALL be exactly PIPE_STAGES cycles from the input transfer to out_valid with no stall. Throughput SHALL be one result per cycle.
REQ-020 While stalled, product and out_valid SHALL hold stable, and no stage SHALL change.
REQ-021 The product SHALL be the full 2*WIDTH-bit result, with no truncation and no overflow.
REQ-022 When in_valid is 0 on an advancing cycle, a bubble (valid=0) SHALL enter stage 1.
REQ-023 in_flight update rules:
- +1 on an input transfer.
- -1 on an output transfer.
- Unchanged when both occur in the same cycle.
REQ-024 product SHALL retain its last value when out_valid is 0; the bench checks it only when out_valid is 1.

Reset
REQ-025 While rst is 1, every stage valid bit SHALL be 0, and out_valid, product and in_flight SHALL be 0.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight operands; no result from before reset SHALL appear afterwards.
REQ-027 in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-028 Macro WALLACE_SIGNED_EN defined:
- signed_mode port exists.
- signed_mode is captured with each operand pair and travels with it.
- When signed_mode is 1, Baugh-Wooley sign correction SHALL produce the two's-complement product.
REQ-029 Macro WALLACE_SIGNED_EN undefined: the signed_mode port is absent and all operands are unsigned.

Verification
REQ-030 WIDTH=32, PIPE_STAGES=3: a=3, b=5, out_ready=1 -> out_valid rises 3 cycles later, product=15.
REQ-031 a=b=0xFFFFFFFF unsigned -> product=0xFFFFFFFE00000001.
REQ-032 WALLACE_SIGNED_EN defined, signed_mode=1, a=b=0xFFFFFFFF -> product=1; a=0x80000000, b=2 -> product=0xFFFFFFFF00000000.
REQ-033 Back-to-back inputs 1x1..8x8 with out_ready=1 -> eight results 1,4,...,64 on consecutive cycles; in_flight stays at 3 in steady state.
REQ-034 out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 during the stall, product held, no result lost or duplicated, in_flight never exceeds 3.
REQ-035 rst pulsed with 2 operands in flight -> out_valid=0 and in_flight=0 immediately; the old results never appear; the next input completes in 3 cycles.
